ft_tx_arbiter: RTL and testbench

Shares the FT232H FT245 synchronous-FIFO write path between the camera's data producers: the CCD pixel stream, AD9826 register readback and MCP3008 telemetry. Each producer presents byte packets on a valid/ready stream. The arbiter grants one packet at a time in round-robin order, prefixes it with a source header byte and drives the FT245 write strobes. It sits between the producers and the FT245 pad logic in the FT clock domain. It yields the bus immediately whenever the receive path owns it.

---
 rtl/ft_pkg.sv | 34 +++
 rtl/ft_tx_arbiter_if.sv | 33 +++
 rtl/rr_pick.sv | 48 ++++
 rtl/ft_tx_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_ft_tx_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ft_pkg.sv
`default_nettype none
//==============================================================================
// Module      : ft_pkg
// Description : Shared definitions for the FT245 transmit arbiter: header tag,
//               source identifiers, index width, FSM state encoding and the
//               header-byte builder.
// Revision    : 1.0 - initial release
//==============================================================================
package ft_pkg;

    // Upper nibble of every packet header byte
    localparam logic [3:0] HDR_TAG    = 4'hA;

    // Source identifiers carried in the low bits of the header
    localparam logic [1:0] SRC_CCD    = 2'd0;
    localparam logic [1:0] SRC_ADCONF = 2'd1;
    localparam logic [1:0] SRC_MCP    = 2'd2;

    // Requester index width (up to four requesters)
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Header byte: {tag, 2'b00, source id}
    function automatic logic [7:0] make_hdr(input logic [IDX_W-1:0] src);
        return {HDR_TAG, 2'b00, src};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ft_tx_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module      : ft_tx_arbiter_if
// Description : Producer-side byte streams for the FT245 transmit arbiter.
//               One valid/ready/last lane per requester; requester i data sits
//               at req_data[8i+7:8i].
//   master : producers (drive valid/data/last, observe ready)
//   slave  : arbiter   (observe valid/data/last, drive ready)
// Revision    : 1.0 - initial release
//==============================================================================
interface ft_tx_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        output req_ready
    );
endinterface
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
//==============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Searches the request vector
//               starting one past last_idx and returns the first requester as
//               a one-hot vector plus its index.
//   req      in  NREQ   request vector
//   last_idx in  IDX_W  index of the previous owner
//   gnt      out NREQ   one-hot winner (0 when no request)
//   idx      out IDX_W  winner index
// Revision    : 1.0 - initial release
//==============================================================================
module rr_pick
    import ft_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  wire logic [NREQ-1:0]  req,
    input  wire logic [IDX_W-1:0] last_idx,
    output logic      [NREQ-1:0]  gnt,
    output logic      [IDX_W-1:0] idx
);

    always_comb begin : p_pick
        int               k;
        logic [IDX_W-1:0] w_k;
        logic             w_found;
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        k       = 0;
        w_k     = '0;
        for (int off = 1; off <= NREQ; off++) begin
            k = int'(last_idx) + off;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            w_k = IDX_W'(k);
            if (!w_found && req[w_k]) begin
                w_found  = 1'b1;
                gnt[w_k] = 1'b1;
                idx      = w_k;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ft_tx_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : ft_tx_arbiter
// Description : Round-robin arbiter sharing the FT245 synchronous-FIFO write
//               path between byte-stream producers. Each granted packet is
//               prefixed by a source header byte; the receive path always has
//               priority over the bus.
//   clk, rst     in   FT clock and synchronous active-high reset
//   req          if   producer streams (slave modport)
//   rd_active    in   receive side owns the bus
//   ft_txe_n     in   FT232H TX FIFO has space (active low)
//   tx_data      out  byte to the pads
//   tx_drive     out  pad output enable
//   ft_wr_n      out  write strobe (active low)
//   ft_siwu_n    out  send-immediate pulse after each packet (active low)
//   grant        out  one-hot current owner
//   busy         out  not idle
//   err_timeout  out  sticky mid-packet stall abort flag
//   err_clr      in   clears err_timeout
// Revision    : 1.0 - initial release
//==============================================================================
module ft_tx_arbiter
    import ft_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 1024,
    parameter bit SIWU_EN = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ft_tx_arbiter_if.slave   req,
    input  wire logic        rd_active,
    input  wire logic        ft_txe_n,
    output logic      [7:0]  tx_data,
    output logic             tx_drive,
    output logic             ft_wr_n,
    output logic             ft_siwu_n,
    output logic [NREQ-1:0]  grant,
    output logic             busy,
    output logic             err_timeout,
    input  wire logic        err_clr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             r_state,      w_state_nxt;
    logic [7:0]         r_obuf_data,  w_obuf_data_nxt;
    logic               r_obuf_last,  w_obuf_last_nxt;
    logic               r_obuf_valid, w_obuf_valid_nxt;
    logic [NREQ-1:0]    r_grant,      w_grant_nxt;
    logic [IDX_W-1:0]   r_gidx,       w_gidx_nxt;
    logic [IDX_W-1:0]   r_last_idx,   w_last_idx_nxt;
    logic [CNT_W-1:0]   r_cnt,        w_cnt_nxt;
    logic               r_err,        w_err_nxt;
    logic               r_siwu_n,     w_siwu_n_nxt;

    logic [NREQ-1:0]    w_pick_gnt;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_xfer;
    logic               w_valid_g;
    logic               w_last_g;
    logic [7:0]         w_data_g;
    logic               w_ready_g;
    logic               w_accept;
    logic               w_abort;
    logic [NREQ-1:0]    w_ready_vec;

    rr_pick #(
        .NREQ     (NREQ)
    ) u_rr_pick (
        .req      (req.req_valid),
        .last_idx (r_last_idx),
        .gnt      (w_pick_gnt),
        .idx      (w_pick_idx)
    );

    // Transfer depends only on registered obuf state plus the pad inputs
    assign w_xfer    = r_obuf_valid & ~rd_active & ~ft_txe_n;
    assign w_valid_g = req.req_valid[r_gidx];
    assign w_last_g  = req.req_last[r_gidx];
    assign w_data_g  = req.req_data[{r_gidx, 3'b000} +: 8];

    always_comb begin
        w_state_nxt      = r_state;
        w_obuf_data_nxt  = r_obuf_data;
        w_obuf_last_nxt  = r_obuf_last;
        w_obuf_valid_nxt = r_obuf_valid;
        w_grant_nxt      = r_grant;
        w_gidx_nxt       = r_gidx;
        w_last_idx_nxt   = r_last_idx;
        w_cnt_nxt        = r_cnt;
        w_siwu_n_nxt     = 1'b1;
        w_ready_g        = 1'b0;
        w_accept         = 1'b0;
        w_abort          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!rd_active && (|req.req_valid)) begin
                    w_state_nxt      = ST_HDR;
                    w_grant_nxt      = w_pick_gnt;
                    w_gidx_nxt       = w_pick_idx;
                    w_obuf_data_nxt  = make_hdr(w_pick_idx);
                    w_obuf_last_nxt  = 1'b0;
                    w_obuf_valid_nxt = 1'b1;
                    w_cnt_nxt        = '0;
                end
            end

            ST_HDR, ST_DATA: begin
                // Ready is also offered while the header drains so the first
                // payload byte follows the header with no bubble.
                w_ready_g = (~r_obuf_valid | w_xfer) & ~r_obuf_last & ~rd_active;
                w_accept  = w_ready_g & w_valid_g;

                if (w_xfer) begin
                    w_obuf_valid_nxt = 1'b0;
                end
                if (w_accept) begin
                    w_obuf_data_nxt  = w_data_g;
                    w_obuf_last_nxt  = w_last_g;
                    w_obuf_valid_nxt = 1'b1;
                    w_cnt_nxt        = '0;
                end

                if (r_state == ST_HDR) begin
                    if (w_xfer) begin
                        w_state_nxt = ST_DATA;
                    end
                end else if (w_xfer && r_obuf_last) begin
                    w_state_nxt    = ST_IDLE;
                    w_grant_nxt    = '0;
                    w_last_idx_nxt = r_gidx;
                    w_siwu_n_nxt   = ~SIWU_EN;
                end else if (!r_obuf_valid && !w_valid_g) begin
                    // Stalled producer: abandon the packet once the idle
                    // count reaches TIMEOUT; host resyncs on the next header.
                    if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        w_abort        = 1'b1;
                        w_state_nxt    = ST_IDLE;
                        w_grant_nxt    = '0;
                        w_last_idx_nxt = r_gidx;
                        w_cnt_nxt      = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Set has priority over clear
        if (w_abort) begin
            w_err_nxt = 1'b1;
        end else if (err_clr) begin
            w_err_nxt = 1'b0;
        end else begin
            w_err_nxt = r_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_obuf_data  <= '0;
            r_obuf_last  <= 1'b0;
            r_obuf_valid <= 1'b0;
            r_grant      <= '0;
            r_gidx       <= '0;
            r_last_idx   <= IDX_W'(NREQ - 1);
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_siwu_n     <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_obuf_data  <= w_obuf_data_nxt;
            r_obuf_last  <= w_obuf_last_nxt;
            r_obuf_valid <= w_obuf_valid_nxt;
            r_grant      <= w_grant_nxt;
            r_gidx       <= w_gidx_nxt;
            r_last_idx   <= w_last_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_err        <= w_err_nxt;
            r_siwu_n     <= w_siwu_n_nxt;
        end
    end

    always_comb begin
        w_ready_vec         = '0;
        w_ready_vec[r_gidx] = w_ready_g;
    end

    assign req.req_ready = w_ready_vec;
    assign tx_data       = r_obuf_data;
    assign busy          = (r_state != ST_IDLE);
    assign tx_drive      = busy & ~rd_active;
    assign ft_wr_n       = ~(r_obuf_valid & ~rd_active);
    assign ft_siwu_n     = r_siwu_n;
    assign grant         = r_grant;
    assign err_timeout   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ft_tx_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_ft_tx_arbiter
// Description : Self-checking bench for ft_tx_arbiter. Producers are fed from
//               per-requester byte queues; every byte expected on the FT bus is
//               pushed to a scoreboard queue and popped on each write transfer.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_ft_tx_arbiter;

    localparam int NREQ = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd_active;
    logic       ft_txe_n;
    logic [7:0] tx_data;
    logic       tx_drive;
    logic       ft_wr_n;
    logic       ft_siwu_n;
    logic [NREQ-1:0] grant;
    logic       busy;
    logic       err_timeout;
    logic       err_clr;

    int n_assert = 0;
    int n_fail   = 0;

    logic [8:0]      src_q [NREQ][$];   // {last, data}
    logic [8:0]      exp_q [$];         // {last, data}
    logic [NREQ-1:0] acc;
    logic            siwu_due;

    ft_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    ft_tx_arbiter #(
        .NREQ        (NREQ),
        .TIMEOUT     (8),
        .SIWU_EN     (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (bus),
        .rd_active   (rd_active),
        .ft_txe_n    (ft_txe_n),
        .tx_data     (tx_data),
        .tx_drive    (tx_drive),
        .ft_wr_n     (ft_wr_n),
        .ft_siwu_n   (ft_siwu_n),
        .grant       (grant),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_src(input int src, input logic [7:0] d, input logic last);
        src_q[src].push_back({last, d});
    endtask

    task automatic push_exp(input logic [7:0] d, input logic last);
        exp_q.push_back({last, d});
    endtask

    // Header then payload on the scoreboard, payload into the producer queue
    task automatic send_pkt(input int src, input int len, input logic [7:0] base);
        push_exp({4'hA, 2'b00, 2'(src)}, 1'b0);
        for (int i = 0; i < len; i++) begin
            push_src(src, base + 8'(i), (i == len - 1));
            push_exp(base + 8'(i), (i == len - 1));
        end
    endtask

    task automatic drain(input string tag, input int max_cyc);
        for (int c = 0; c < max_cyc; c++) begin
            if (exp_q.size() == 0 && !busy) break;
            step();
        end
        chk({tag, "_drain"}, exp_q.size(), 0);
        step();
    endtask

    task automatic wait_wr(input string tag, input int max_cyc);
        for (int c = 0; c < max_cyc; c++) begin
            if (!ft_wr_n) break;
            step();
        end
        chk({tag, "_wr_start"}, ft_wr_n, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        exp_q.delete();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_n"},     ft_wr_n,       1);
        chk({tag, "_tx_drive"}, tx_drive,      0);
        chk({tag, "_siwu_n"},   ft_siwu_n,     1);
        chk({tag, "_grant"},    grant,         0);
        chk({tag, "_ready"},    bus.req_ready, 0);
        chk({tag, "_err"},      err_timeout,   0);
        chk({tag, "_tx_data"},  tx_data,       0);
        chk({tag, "_busy"},     busy,          0);
    endtask

    // Producers: pop on an accepted byte, present the next queue head
    always @(negedge clk) acc = rst ? '0 : (bus.req_valid & bus.req_ready);

    always @(posedge clk) begin
        logic [NREQ-1:0]   v;
        logic [NREQ-1:0]   l;
        logic [8*NREQ-1:0] d;
        #1;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
                v[i]         = 1'b1;
                l[i]         = src_q[i][0][8];
                d[8*i +: 8]  = src_q[i][0][7:0];
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
    end

    // Bus monitor: scoreboard pops on transfer, send-immediate and gap checks
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            siwu_due = 1'b0;
        end else begin
            chk("siwu_n", ft_siwu_n, siwu_due ? 0 : 1);
            if (siwu_due) begin
                chk("grant_after_last", grant, 0);
                chk("gap_wr_n", ft_wr_n, 1);
            end
            siwu_due = 1'b0;
            if (!ft_wr_n && !ft_txe_n) begin
                chk("sb_nonempty", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("tx_data", tx_data, e[7:0]);
                    if (e[8]) siwu_due = 1'b1;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] held;

        rst       = 1'b1;
        rd_active = 1'b0;
        ft_txe_n  = 1'b0;
        err_clr   = 1'b0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        siwu_due  = 1'b0;
        acc       = '0;
        repeat (3) step();
        chk_reset_outputs("por");
        rst = 1'b0;
        step();

        // Single packet from requester 1: A1,11,22,33 back to back
        push_exp(8'hA1, 1'b0);
        push_src(1, 8'h11, 1'b0); push_exp(8'h11, 1'b0);
        push_src(1, 8'h22, 1'b0); push_exp(8'h22, 1'b0);
        push_src(1, 8'h33, 1'b1); push_exp(8'h33, 1'b1);
        wait_wr("single", 10);
        chk("single_grant", grant, 3'b010);
        for (int k = 0; k < 4; k++) begin
            chk("single_consec_wr", ft_wr_n, 0);
            step();
        end
        chk("single_end_wr", ft_wr_n, 1);
        drain("single", 20);

        // Round-robin from reset: A0, A1, A2, A0
        do_reset();
        send_pkt(0, 2, 8'h01);
        send_pkt(1, 2, 8'h11);
        send_pkt(2, 2, 8'h21);
        send_pkt(0, 2, 8'h05);
        drain("rr", 60);

        // TX FIFO full for 5 cycles mid-packet
        send_pkt(1, 6, 8'h40);
        wait_wr("txe", 10);
        step(); step();
        ft_txe_n = 1'b1;
        #1;
        held = tx_data;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("txe_wr_n", ft_wr_n, 0);
            chk("txe_hold", tx_data, held);
            chk("txe_ready", bus.req_ready, 0);
            step();
        end
        ft_txe_n = 1'b0;
        drain("txe", 40);

        // Receive side takes the bus for 4 cycles during DATA
        send_pkt(2, 6, 8'h60);
        wait_wr("rd", 10);
        step(); step();
        rd_active = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rd_wr_n", ft_wr_n, 1);
            chk("rd_tx_drive", tx_drive, 0);
            chk("rd_ready", bus.req_ready, 0);
            step();
        end
        rd_active = 1'b0;
        drain("rd", 40);

        // Timeout: req0 stalls after one byte, req2 pending
        do_reset();
        push_exp(8'hA0, 1'b0);
        push_src(0, 8'h55, 1'b0); push_exp(8'h55, 1'b0);
        send_pkt(2, 2, 8'h66);
        for (int c = 0; c < 60; c++) begin
            if (err_timeout) break;
            step();
        end
        chk("to_err_set", err_timeout, 1);
        drain("to", 40);
        chk("to_err_sticky", err_timeout, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("to_err_clr", err_timeout, 0);

        // Reset during DATA, then req0 wins first
        send_pkt(1, 6, 8'h80);
        wait_wr("rstmid", 10);
        step(); step();
        chk("rstmid_busy", busy, 1);
        do_reset();
        #1;
        chk_reset_outputs("rstmid");
        send_pkt(0, 2, 8'h90);
        send_pkt(1, 2, 8'hB0);
        wait_wr("rstmid2", 10);
        chk("rstmid_first_grant", grant, 3'b001);
        drain("rstmid", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
